// File: rtl/fft_modulus_fifo_reader.sv
// Purpose : drains the FFT modulus FIFO into a valid/ready stream tagged with bin/last,
//           and reports the per-frame peak modulus and its bin at each frame end.
// Latency : 2 cycles from FIFO pop to m_valid (FIFO read + skid register); 1 beat/clock sustained.
// Backpr. : m_ready low fills the 2-entry skid buffer, then pops stop; nothing is dropped.
//
// Ports:
//   rd_clk, rd_rst                  clock (also FIFO read clock), async active-high reset
//   frame_en                        1 = stream frames, 0 = stop at the next frame boundary
//   fifo_rd_en/fifo_data/fifo_empty FIFO read port (data valid the cycle after a pop)
//   fifo_oce                        FIFO output-register enable, high out of reset
//   m_valid/m_ready/m_data/m_bin/m_last   output stream
//   peak_valid/peak_mag/peak_bin    frame peak report (mag/bin held between reports)
//   frame_cnt                       completed frames, wraps
//   busy                            FSM active or words still buffered / in flight
module fft_modulus_fifo_reader #(
    parameter int DATA_W    = 32,
    parameter int FRAME_LEN = 1024,   // 2..65536
    parameter int BIN_W     = 10,     // 2**BIN_W >= FRAME_LEN
    parameter int FCNT_W    = 16
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic              frame_en,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_empty,
    output logic              fifo_oce,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [BIN_W-1:0]  m_bin,
    output logic              m_last,
    output logic              peak_valid,
    output logic [DATA_W-1:0] peak_mag,
    output logic [BIN_W-1:0]  peak_bin,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              busy
);

    localparam logic [BIN_W-1:0]  LAST_BIN = BIN_W'(FRAME_LEN - 1);
    localparam logic [BIN_W-1:0]  BIN_ONE  = BIN_W'(1);
    localparam logic [FCNT_W-1:0] FCNT_ONE = FCNT_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t            state, state_nxt;
    logic              allow;
    logic [1:0]        occ;        // skid entries held
    logic              infl;       // pop issued last cycle; its word lands this cycle
    logic [DATA_W-1:0] skid0;      // head entry, drives m_data
    logic [DATA_W-1:0] skid1;
    logic [BIN_W-1:0]  pop_cnt;    // pops issued within the current frame
    logic [DATA_W-1:0] run_mag;
    logic [BIN_W-1:0]  run_bin;
    logic              beat;
    logic              take;
    logic [DATA_W-1:0] cand_mag;
    logic [BIN_W-1:0]  cand_bin;
    logic [2:0]        fill_now;
    logic [2:0]        fill_lim;

    assign fifo_oce = ~rd_rst;
    assign m_valid  = (occ != 2'd0);
    assign m_data   = skid0;
    assign m_last   = (m_bin == LAST_BIN);
    assign beat     = m_valid & m_ready;
    assign busy     = (state != IDLE) | (occ != 2'd0) | infl;

    // Pop only if the word it brings can still find a free entry once this
    // cycle's landing word and departing beat are accounted for.
    assign fill_now   = {1'b0, occ} + {2'b00, infl};
    assign fill_lim   = 3'd2 + {2'b00, beat};
    assign fifo_rd_en = allow & ~fifo_empty & (fill_now < fill_lim);

    // ---------------- frame FSM ----------------
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        allow     = 1'b0;
        case (state)
            IDLE: begin
                if (frame_en) state_nxt = RUN;
            end
            RUN: begin
                // When stopping exactly at a boundary, do not open a new frame.
                allow = frame_en | (pop_cnt != '0);
                if (!frame_en) state_nxt = (pop_cnt == '0) ? IDLE : STOP;
            end
            STOP: begin
                // Finish the partial frame; frame_en returning resumes without a gap.
                allow = frame_en | (pop_cnt != '0);
                if (frame_en)
                    state_nxt = RUN;
                else if ((pop_cnt == '0) || (fifo_rd_en && (pop_cnt == LAST_BIN)))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- pop bookkeeping ----------------
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            infl    <= 1'b0;
            pop_cnt <= '0;
        end else begin
            infl <= fifo_rd_en;
            if (fifo_rd_en) pop_cnt <= (pop_cnt == LAST_BIN) ? '0 : pop_cnt + BIN_ONE;
        end
    end

    // ---------------- 2-entry skid buffer ----------------
    // Push comes from the word landing this cycle (infl), pop is the output beat.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            occ   <= 2'd0;
            skid0 <= '0;
            skid1 <= '0;
        end else begin
            case ({infl, beat})
                2'b10: begin
                    if (occ == 2'd0) skid0 <= fifo_data;
                    else             skid1 <= fifo_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    skid0 <= skid1;
                    occ   <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        skid0 <= fifo_data;
                    end else begin
                        skid0 <= skid1;
                        skid1 <= fifo_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- bin tag and peak tracking ----------------
    // Bin 0 always seeds the running peak; later bins need a strict win so
    // the first occurrence of the maximum keeps its bin.
    assign take     = (m_bin == '0) || (m_data > run_mag);
    assign cand_mag = take ? m_data : run_mag;
    assign cand_bin = take ? m_bin  : run_bin;

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            m_bin      <= '0;
            run_mag    <= '0;
            run_bin    <= '0;
            peak_valid <= 1'b0;
            peak_mag   <= '0;
            peak_bin   <= '0;
            frame_cnt  <= '0;
        end else begin
            peak_valid <= beat & m_last;
            if (beat) begin
                m_bin   <= m_last ? '0 : m_bin + BIN_ONE;
                run_mag <= cand_mag;
                run_bin <= cand_bin;
                if (m_last) begin
                    peak_mag  <= cand_mag;
                    peak_bin  <= cand_bin;
                    frame_cnt <= frame_cnt + FCNT_ONE;
                end
            end
        end
    end

endmodule
